// File: rtl/display_pkg.sv
// Shared types and defaults for the display arbiter.
// The state encoding is chosen so that each state value is also its grant vector.
package display_pkg;

    localparam int DATA_W_DEFAULT = 16;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        OWN0 = 2'b01,
        OWN1 = 2'b10
    } state_t;

endpackage

// File: rtl/dwell_timer.sv
// Ownership dwell counter: cleared on an ownership change, counts while enabled,
// and saturates at DWELL_CYCLES-1, where it signals expiry.
module dwell_timer #(
    parameter int DWELL_CYCLES = 25000000,
    localparam int CNT_W = $clog2(DWELL_CYCLES + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL_CYCLES - 1);

    logic [CNT_W-1:0] cnt;

    // NOTE: sequential state is written with <= only, so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable && !expired) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign expired = (cnt == CNT_LAST);

endmodule

// File: rtl/display_arbiter.sv
// Two-requester round-robin display arbiter with a minimum dwell per grant.
// Optional macro DISPLAY_ARB_BLANK_IDLE_EN clears disp_data on entering IDLE.
module display_arbiter
    import display_pkg::*;
#(
    parameter int DWELL_CYCLES = 25000000,
    parameter int DATA_W       = DATA_W_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        req,
    input  logic [DATA_W-1:0] data0,
    input  logic [DATA_W-1:0] data1,
    output logic [1:0]        grant,
    output logic [DATA_W-1:0] disp_data,
    output logic              disp_blank
);

    state_t            state;
    state_t            state_next;
    logic              last;
    logic              last_next;
    logic [DATA_W-1:0] data_next;
    logic              expired;

    // Any state change restarts the dwell, so a hand-over starts the new owner at zero.
    dwell_timer #(
        .DWELL_CYCLES(DWELL_CYCLES)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .clear  (state_next != state),
        .enable (state != IDLE),
        .expired(expired)
    );

    // Outputs are registered from the next-state values so grant and data move together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            last       <= 1'b1;
            grant      <= 2'b00;
            disp_data  <= '0;
            disp_blank <= 1'b1;
        end else begin
            state      <= state_next;
            last       <= last_next;
            grant      <= state_next;
            disp_data  <= data_next;
            disp_blank <= (state_next == IDLE);
        end
    end

    // NOTE: every comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                unique case (req)
                    2'b01:   state_next = OWN0;
                    2'b10:   state_next = OWN1;
                    2'b11:   state_next = last ? OWN0 : OWN1;
                    default: state_next = IDLE;
                endcase
            end
            OWN0: begin
                if (expired) begin
                    if (req[1])      state_next = OWN1;
                    else if (req[0]) state_next = OWN0;
                    else             state_next = IDLE;
                end
            end
            OWN1: begin
                if (expired) begin
                    if (req[0])      state_next = OWN0;
                    else if (req[1]) state_next = OWN1;
                    else             state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        last_next = last;
        data_next = disp_data;
        unique case (state_next)
            OWN0: begin
                last_next = 1'b0;
                if (state != OWN0 || req[0]) data_next = data0;
            end
            OWN1: begin
                last_next = 1'b1;
                if (state != OWN1 || req[1]) data_next = data1;
            end
            default: begin
`ifdef DISPLAY_ARB_BLANK_IDLE_EN
                data_next = '0;
`else
                data_next = disp_data;
`endif
            end
        endcase
    end

endmodule

// File: tb/tb_display_arbiter.sv
// Directed self-checking bench for display_arbiter with DWELL_CYCLES = 4.
module tb_display_arbiter;

    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [1:0]    req = 2'b00;
    logic [DW-1:0] data0 = '0;
    logic [DW-1:0] data1 = '0;
    logic [1:0]    grant;
    logic [DW-1:0] disp_data;
    logic          disp_blank;

    int total = 0;
    int bad   = 0;
    logic inv_en = 1'b0;
    logic [DW-1:0] idle_word;

    display_arbiter #(.DWELL_CYCLES(4), .DATA_W(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .data0     (data0),
        .data1     (data1),
        .grant     (grant),
        .disp_data (disp_data),
        .disp_blank(disp_blank)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string tag, input logic [1:0] g, input logic [DW-1:0] d);
        check({tag, "_grant"}, 32'(grant), 32'(g));
        check({tag, "_data"}, 32'(disp_data), 32'(d));
        check({tag, "_blank"}, 32'(disp_blank), 32'(g == 2'b00));
    endtask

    always @(negedge clk) begin
        if (inv_en) begin
            check("inv_onehot", 32'(grant == 2'b11), 32'(0));
            check("inv_blank", 32'(disp_blank), 32'(grant == 2'b00));
        end
    end

    initial begin
        // Reset and idle for 10 cycles
        rst = 1'b1;
        step();
        inv_en = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            expect_out("idle", 2'b00, 16'h0000);
        end

        // Requester 0 alone: grant in one cycle, data tracking, then freeze and release
        data0 = 16'h1234;
        req   = 2'b01;
        step();
        expect_out("r0_grant", 2'b01, 16'h1234);
        data0 = 16'hBEEF;
        step();
        expect_out("r0_track", 2'b01, 16'hBEEF);
        req   = 2'b00;
        data0 = 16'h1111;
        step();
        expect_out("r0_frozen2", 2'b01, 16'hBEEF);
        step();
        expect_out("r0_frozen3", 2'b01, 16'hBEEF);
`ifdef DISPLAY_ARB_BLANK_IDLE_EN
        idle_word = 16'h0000;
`else
        idle_word = 16'hBEEF;
`endif
        step();
        expect_out("r0_release", 2'b00, idle_word);

        // Both requesting from a fresh reset: 4/4/4 alternation with no idle gap
        rst = 1'b1;
        step();
        rst = 1'b0;
        expect_out("rst_b", 2'b00, 16'h0000);
        data0 = 16'hAAAA;
        data1 = 16'h5555;
        req   = 2'b11;
        for (int i = 0; i < 12; i++) begin
            step();
            if ((i / 4) == 1) expect_out("rr_own1", 2'b10, 16'h5555);
            else              expect_out("rr_own0", 2'b01, 16'hAAAA);
        end

        // One-cycle pulse: dwell still holds for 4 cycles with the word frozen
        rst = 1'b1;
        req = 2'b00;
        step();
        rst = 1'b0;
        data0 = 16'h00C3;
        req   = 2'b01;
        step();
        expect_out("pulse_c0", 2'b01, 16'h00C3);
        data0 = 16'hFFFF;
        req   = 2'b00;
        for (int i = 1; i < 4; i++) begin
            step();
            expect_out("pulse_hold", 2'b01, 16'h00C3);
        end
        step();
`ifdef DISPLAY_ARB_BLANK_IDLE_EN
        idle_word = 16'h0000;
`else
        idle_word = 16'h00C3;
`endif
        expect_out("pulse_idle", 2'b00, idle_word);

        // Reset two cycles into OWN1 aborts the dwell; tie after release goes to requester 0
        data1 = 16'h0F0F;
        req   = 2'b10;
        step();
        expect_out("own1_c0", 2'b10, 16'h0F0F);
        step();
        expect_out("own1_c1", 2'b10, 16'h0F0F);
        rst = 1'b1;
        step();
        expect_out("mid_rst", 2'b00, 16'h0000);
        check("mid_rst_cnt", 32'(dut.u_timer.cnt), 32'(0));
        rst   = 1'b0;
        data0 = 16'h7E57;
        req   = 2'b11;
        step();
        expect_out("post_rst_tie", 2'b01, 16'h7E57);

        // Release with no request: no grant follows the reset release
        rst = 1'b1;
        req = 2'b00;
        step();
        rst = 1'b0;
        step();
        expect_out("rel_noreq", 2'b00, 16'h0000);

        @(posedge clk);
        inv_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
